// File: rtl/bool_expr_sweeper.sv
// bool_expr_sweeper: drives an external four-input expression unit through all
// sixteen input vectors and counts how often each of its five outputs is 1.
// Each vector is held for SETTLE+1 cycles, then the outputs are sampled.
// Optional feature: define SWEEP_MISR_EN to add the 16-bit MISR signature
// output 'sig', computed over every sampled y.
module bool_expr_sweeper #(
  parameter int SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic [4:0]  y,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [24:0] ones_cnt
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0] sig
`endif
);

  localparam logic [3:0] SETTLE_CYC = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  vec_idx_reg;
  logic [3:0]  hold_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [4:0]  cnt_reg [5];

  logic        start_acc;
  logic        sample;

  // A start is only honoured from IDLE, and a simultaneous abort vetoes it.
  assign start_acc = (state_reg == IDLE) && start && !abort;
  // Sample on the last hold cycle of a vector; an abort that edge suppresses it.
  assign sample    = (state_reg == SWEEP) && !abort && (hold_reg == SETTLE_CYC);

  // Sweep control: state, vector index, hold counter and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      vec_idx_reg <= 4'd0;
      hold_reg    <= 4'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start_acc) begin
            state_reg   <= SWEEP;
            vec_idx_reg <= 4'd0;
            hold_reg    <= 4'd0;
            busy_reg    <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (sample) begin
            hold_reg <= 4'd0;
            if (vec_idx_reg == 4'd15) begin
              // Last vector: vec_idx stays at 15 so the final drive remains visible.
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              vec_idx_reg <= vec_idx_reg + 4'd1;
            end
          end else begin
            hold_reg <= hold_reg + 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // One ones-counter per expression output; at most 16 samples so 5 bits never wrap.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
      // Clear on reset or accepted start, accumulate y[gi] on each sample, else hold.
      always_ff @(posedge clk) begin
        if (rst || start_acc) begin
          cnt_reg[gi] <= 5'd0;
        end else if (sample) begin
          cnt_reg[gi] <= cnt_reg[gi] + {4'd0, y[gi]};
        end
      end
      assign ones_cnt[5*gi+4:5*gi] = cnt_reg[gi];
    end
  endgenerate

`ifdef SWEEP_MISR_EN
  logic [15:0] sig_reg;

  // CRC-16/CCITT style MISR: shift, feed back 0x1021, then fold in the sampled y.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sig_reg <= 16'hFFFF;
    end else if (sample) begin
      sig_reg <= ({sig_reg[14:0], 1'b0} ^ (sig_reg[15] ? 16'h1021 : 16'h0000)) ^ {11'd0, y};
    end
  end

  assign sig = sig_reg;
`endif

  assign {a, b, c, d} = vec_idx_reg;
  assign vec_idx      = vec_idx_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_bool_expr_sweeper.sv
// Bench for bool_expr_sweeper: one instance with SETTLE=0 driven from a
// scenario table, one with SETTLE=2 for the long-hold sequence. Both face a
// five-function expression unit modelled here in the bench.
module tb_bool_expr_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0, abort0 = 1'b0, tie0 = 1'b0;
  logic        a0, b0, c0, d0, busy0, done0;
  logic [3:0]  vec0;
  logic [4:0]  y0;
  logic [24:0] cnt0;

  logic        start2 = 1'b0, abort2 = 1'b0;
  logic        a2, b2, c2, d2, busy2, done2;
  logic [3:0]  vec2;
  logic [4:0]  y2;
  logic [24:0] cnt2;

`ifdef SWEEP_MISR_EN
  logic [15:0] sig0, sig2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Expression unit: y1=ab|cd, y2=abc, y3=a(b|c), y4=a|b, y5=a|b|c.
  function automatic logic [4:0] expr_f(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {a | b | c, a | b, a & (b | c), a & b & c, (a & b) | (c & d)};
  endfunction

  assign y0 = tie0 ? 5'b11111 : expr_f({a0, b0, c0, d0});
  assign y2 = expr_f({a2, b2, c2, d2});

  bool_expr_sweeper #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .a(a0), .b(b0), .c(c0), .d(d0), .y(y0),
    .vec_idx(vec0), .busy(busy0), .done(done0), .ones_cnt(cnt0)
`ifdef SWEEP_MISR_EN
    , .sig(sig0)
`endif
  );

  bool_expr_sweeper #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .c(c2), .d(d2), .y(y2),
    .vec_idx(vec2), .busy(busy2), .done(done2), .ones_cnt(cnt2)
`ifdef SWEEP_MISR_EN
    , .sig(sig2)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        tie;
    int          abort_at;
    logic [24:0] exp_cnt;
  } scen_t;

  scen_t tbl [5];

`ifdef SWEEP_MISR_EN
  function automatic logic [15:0] misr_full();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < 16; v++)
      s = ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {11'd0, expr_f(4'(v))};
    return s;
  endfunction
`endif

  // One SETTLE=0 sweep from the table, checked cycle by cycle.
  task automatic run0(input int idx);
    bit aborted;
    aborted = 0;
    tie0   = tbl[idx].tie;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk({tbl[idx].name, " busy_after_start"}, 32'(busy0), 32'd1);
    chk({tbl[idx].name, " cnt_cleared"}, 32'(cnt0), 32'd0);
    for (int v = 0; v < 16; v++) begin
      chk($sformatf("%s vec%0d", tbl[idx].name, v), {24'd0, vec0, a0, b0, c0, d0},
          {24'd0, 4'(v), 4'(v)});
      if (v == tbl[idx].abort_at) begin
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk({tbl[idx].name, " abort_busy"}, 32'(busy0), 32'd0);
        chk({tbl[idx].name, " abort_done"}, 32'(done0), 32'd0);
        chk({tbl[idx].name, " abort_cnt"}, 32'(cnt0), 32'(tbl[idx].exp_cnt));
        step();
        chk({tbl[idx].name, " abort_no_late_done"}, 32'(done0), 32'd0);
        aborted = 1;
        break;
      end
      step();
    end
    if (!aborted) begin
      chk({tbl[idx].name, " done_at_k17"}, {30'd0, done0, busy0}, 32'd2);
      chk({tbl[idx].name, " vec_holds_15"}, 32'(vec0), 32'd15);
      chk({tbl[idx].name, " cnt"}, 32'(cnt0), 32'(tbl[idx].exp_cnt));
`ifdef SWEEP_MISR_EN
      if (!tbl[idx].tie) chk({tbl[idx].name, " sig"}, 32'(sig0), 32'(misr_full()));
`endif
      step();
      chk({tbl[idx].name, " done_one_cycle"}, {30'd0, done0, busy0}, 32'd0);
      chk({tbl[idx].name, " cnt_hold_idle"}, 32'(cnt0), 32'(tbl[idx].exp_cnt));
    end
    $display("[TB] scenario %s complete, ones_cnt=0x%0h", tbl[idx].name, cnt0);
  endtask

  initial begin
    tbl[0] = '{"full_expr",  1'b0, -1, {5'd14, 5'd12, 5'd6, 5'd2, 5'd7}};
    tbl[1] = '{"saturate",   1'b1, -1, 25'h1084210};
    tbl[2] = '{"abort5",     1'b1,  5, {5'd5, 5'd5, 5'd5, 5'd5, 5'd5}};
    tbl[3] = '{"full_again", 1'b0, -1, {5'd14, 5'd12, 5'd6, 5'd2, 5'd7}};
    tbl[4] = '{"abort8",     1'b0,  8, {5'd6, 5'd4, 5'd0, 5'd0, 5'd2}};

    // Reset state.
    step();
    step();
    rst = 1'b0;
    chk("reset_state", {9'd0, busy0, done0, vec0, a0, b0, c0, d0, cnt0[13:0]}, 32'd0);
    chk("reset_cnt", 32'(cnt0), 32'd0);

    // start together with abort in IDLE is ignored.
    start0 = 1'b1;
    abort0 = 1'b1;
    step();
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("start_with_abort_ignored", 32'(busy0), 32'd0);

    for (int i = 0; i < 5; i++) run0(i);

    // Reset mid-sweep, held 2 cycles, with start asserted during reset.
    tie0   = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_reset_cnt", 32'(cnt0), {7'd0, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6});
    rst    = 1'b1;
    start0 = 1'b1;
    step();
    step();
    rst    = 1'b0;
    start0 = 1'b0;
    chk("midsweep_reset", {25'd0, busy0, done0, vec0, 1'b0}, 32'd0);
    chk("midsweep_reset_abcd", {28'd0, a0, b0, c0, d0}, 32'd0);
    chk("midsweep_reset_cnt", 32'(cnt0), 32'd0);
    step();
    chk("reset_beats_start", 32'(busy0), 32'd0);
    $display("[TB] reset sequence complete");

    // SETTLE=2: three cycles per vector, extra start pulses ignored.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 48; cyc++) begin
      chk($sformatf("s2_cyc%0d", cyc), {27'd0, busy2, vec2}, {27'd0, 1'b1, 4'((cyc - 1) / 3)});
      start2 = (cyc == 10 || cyc == 30);
      step();
      start2 = 1'b0;
    end
    chk("s2_done_at_k49", {30'd0, done2, busy2}, 32'd2);
    chk("s2_cnt", 32'(cnt2), {7'd0, 5'd14, 5'd12, 5'd6, 5'd2, 5'd7});
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("s2_start_in_done_ignored", {30'd0, done2, busy2}, 32'd0);
    chk("s2_cnt_hold", 32'(cnt2), {7'd0, 5'd14, 5'd12, 5'd6, 5'd2, 5'd7});
    $display("[TB] settle2 sequence complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bool_expr_sweeper.md
BOOL_EXPR_SWEEPER -- requirements
Module: bool_expr_sweeper

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SETTLE, default 0, SHALL set the extra cycles each input vector is held before its outputs are sampled (range 0..15).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  single-cycle request to begin a sweep; accepted only in IDLE.
REQ-006 abort  in  1  terminates an in-progress sweep.
REQ-007 a, b, c, d  out  1 each  registered drive to the expression unit inputs; {a,b,c,d} = vec_idx, a is MSB.
REQ-008 y  in  5  expression unit outputs returned combinationally; y[0]=y1 .. y[4]=y5.
REQ-009 vec_idx  out  4  current vector under test.
REQ-010 busy  out  1  high while in SWEEP.
REQ-011 done  out  1  one-cycle pulse on sweep completion.
REQ-012 ones_cnt  out  25  five 5-bit counts of sampled ones; bits [5k+4:5k] count y[k].

Function
REQ-013 FSM states SHALL be IDLE, SWEEP and DONE.
REQ-014 IDLE->SWEEP SHALL occur on start=1 and abort=0; start with abort=1 in IDLE SHALL be ignored.
REQ-015 On start acceptance, vec_idx, a..d, hold counter and all ones_cnt fields SHALL be cleared to 0 at the same edge.
REQ-016 In SWEEP each vector SHALL be driven for SETTLE+1 cycles; y SHALL be sampled on the last of those cycles.
REQ-017 Each sample SHALL add y[k] to count k (5-bit, max 16, no wrap possible); vec_idx SHALL then increment.
REQ-018 SWEEP->DONE SHALL occur at the edge sampling vector 15; vec_idx and a..d SHALL hold 15 afterwards.
REQ-019 DONE SHALL last exactly one cycle with done=1, busy=0, then go to IDLE.
REQ-020 Latency: start sampled at edge k gives busy=1 from k+1 to k+16*(SETTLE+1); done=1 in cycle k+16*(SETTLE+1)+1.
REQ-021 start in SWEEP or DONE SHALL be ignored.
REQ-022 abort in SWEEP SHALL return to IDLE at the next edge: no done pulse, no sample taken that edge, ones_cnt keeps its partial values.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 ones_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-025 rst=1 SHALL force IDLE and busy=0, done=0, a=b=c=d=0, vec_idx=0, ones_cnt=0, hold counter=0 at the next edge.
REQ-026 rst SHALL take priority over start and abort in all states, including mid-sweep.

Configuration
REQ-027 Macro SWEEP_MISR_EN, when defined, SHALL add output sig (16 bits), a MISR over sampled y.
REQ-028 With SWEEP_MISR_EN, sig SHALL seed to 16'hFFFF on start acceptance and on reset.
REQ-029 On each sample, sig SHALL update as sig <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ {11'b0,y}.
REQ-030 Without SWEEP_MISR_EN, port sig and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset: assert rst for 2 cycles mid-sweep -> next cycle busy=0, done=0, a..d=0, vec_idx=0, ones_cnt=0.
REQ-032 Full sweep, SETTLE=0: loop a..d through the team's five-function expression unit and pulse start at edge k.
REQ-033 Required response for REQ-032: done=1 in cycle k+17, counts y1..y5 = 7, 2, 6, 12, 14, and vectors presented 0..15 in order.
REQ-034 Saturation edge: tie y=5'b11111 -> all five counts = 16 (ones_cnt = 25'h1084210) at done.
REQ-035 Abort: y=5'b11111, assert abort while vec_idx=5 (5 samples taken) -> IDLE next edge, no done pulse, each count = 5; a start one cycle later sweeps normally.
REQ-036 SETTLE=2: each vector held 3 cycles, done=1 in cycle k+49; start pulses during busy and during the done cycle are ignored.
